// File: rtl/pico_axi_resp_router.sv
// pico_axi_resp_router: steers AXI read-response bursts from one master port back to the slave
// port that issued each request. Requests are queued in grant order, and each queued entry
// carries one burst that ends on rlast. A registered output stage separates master-side
// backpressure from slave-side backpressure.
// Optional feature macro: PICO_RESP_ROUTER_ERR_EN (adds the sticky err_flag output).
module pico_axi_resp_router #(
  parameter int unsigned C_NUM_SLAVE_PORTS     = 4,
  parameter int unsigned LOG_C_NUM_SLAVE_PORTS = 2,
  parameter int unsigned C_DATA_WIDTH          = 128,
  parameter int unsigned C_ORDER_DEPTH         = 16,
  parameter int unsigned LOG_C_ORDER_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_issue,
  input  logic [LOG_C_NUM_SLAVE_PORTS-1:0] req_slave,
  output logic                             order_full,
  output logic [LOG_C_ORDER_DEPTH:0]       outstanding,
`ifdef PICO_RESP_ROUTER_ERR_EN
  output logic                             err_flag,
`endif
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  output logic [C_NUM_SLAVE_PORTS-1:0]     s_axi_rvalid,
  input  logic [C_NUM_SLAVE_PORTS-1:0]     s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rlast
);

  localparam int unsigned PtrW = LOG_C_ORDER_DEPTH + 1;
  localparam int unsigned SelW = LOG_C_NUM_SLAVE_PORTS;

  // Order FIFO storage and pointers; the extra pointer bit tells full from empty.
  logic [SelW-1:0] order_mem [C_ORDER_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0] count;
  logic            fifo_empty;
  logic            push, pop, accept;
  logic [SelW-1:0] head_slave;

  // Output register, carrying its own slave index so a pop cannot redirect it.
  logic                    out_valid_q;
  logic [SelW-1:0]         out_slave_q;
  logic [C_DATA_WIDTH-1:0] out_data_q;
  logic [1:0]              out_resp_q;
  logic                    out_last_q;
  logic                    out_in_range;
  logic                    out_ready;
  logic                    out_taken;

  // FIFO status and handshake decode.
  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    outstanding  = count;
    order_full   = (count == PtrW'(C_ORDER_DEPTH));
    fifo_empty   = (count == '0);
    head_slave   = order_mem[rd_ptr_q[LOG_C_ORDER_DEPTH-1:0]];
    out_in_range = (32'(out_slave_q) < C_NUM_SLAVE_PORTS);
    // An out-of-range beat has no taker, so it is treated as consumed and discarded.
    out_ready    = out_in_range ? s_axi_rready[out_slave_q] : 1'b1;
    out_taken    = out_valid_q && out_ready;
    m_axi_rready = !fifo_empty && (!out_valid_q || out_ready);
    accept       = m_axi_rvalid && m_axi_rready;
    push         = req_issue && !order_full;
    pop          = accept && m_axi_rlast;
  end

  // Order FIFO entry write.
  always_ff @(posedge clk) begin
    if (push) begin
      order_mem[wr_ptr_q[LOG_C_ORDER_DEPTH-1:0]] <= req_slave;
    end
  end

  // Order FIFO pointers; a push while full is dropped regardless of a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Output register: load on master accept, invalidate when drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_slave_q <= '0;
      out_data_q  <= '0;
      out_resp_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_slave_q <= head_slave;
      out_data_q  <= m_axi_rdata;
      out_resp_q  <= m_axi_rresp;
      out_last_q  <= m_axi_rlast;
    end else if (out_taken) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-hot slave valid decode and broadcast payload.
  always_comb begin
    s_axi_rvalid = '0;
    for (int i = 0; i < int'(C_NUM_SLAVE_PORTS); i++) begin
      s_axi_rvalid[i] = out_valid_q && (out_slave_q == SelW'(i));
    end
    s_axi_rdata = out_data_q;
    s_axi_rresp = out_resp_q;
    s_axi_rlast = out_last_q;
  end

`ifdef PICO_RESP_ROUTER_ERR_EN
  logic [3:0] stall_cnt_q;
  logic       err_q;
  logic       stall;
  logic       err_set;

  // Error sources: dropped push, out-of-range push, and a 16-cycle empty-FIFO stall.
  always_comb begin
    stall   = m_axi_rvalid && fifo_empty;
    err_set = (req_issue && order_full)
            || (push && (32'(req_slave) >= C_NUM_SLAVE_PORTS))
            || (stall && (stall_cnt_q == 4'hF));
  end

  // Stall counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (!stall) begin
        stall_cnt_q <= '0;
      end else if (stall_cnt_q != 4'hF) begin
        stall_cnt_q <= stall_cnt_q + 4'd1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_flag = err_q;
`endif

endmodule

// File: tb/tb_pico_axi_resp_router.sv
// Self-checking bench for pico_axi_resp_router: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based reference model of the routing rules.
module tb_pico_axi_resp_router;

  localparam int NS    = 4;
  localparam int DW    = 128;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_issue;
  logic [1:0]    req_slave;
  logic          order_full;
  logic [4:0]    outstanding;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic [NS-1:0] s_axi_rvalid;
  logic [NS-1:0] s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
`ifdef PICO_RESP_ROUTER_ERR_EN
  logic          err_flag;
`endif

  pico_axi_resp_router dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_issue    (req_issue),
    .req_slave    (req_slave),
    .order_full   (order_full),
    .outstanding  (outstanding),
`ifdef PICO_RESP_ROUTER_ERR_EN
    .err_flag     (err_flag),
`endif
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: grant-order queue plus the one pending output beat.
  int            q[$];
  bit            ov;
  int            os;
  logic [DW-1:0] od;
  logic [1:0]    orr;
  bit            ol;
  int            stall_cycles;
  bit            err;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ov = 0; os = 0; od = '0; orr = '0; ol = 0;
    stall_cycles = 0; err = 0;
  endtask

  task automatic check_reset_state();
    check_eq("rst_rvalid", s_axi_rvalid, '0);
    check_eq("rst_outstanding", outstanding, '0);
    check_eq("rst_full", order_full, '0);
    check_eq("rst_mready", m_axi_rready, '0);
    check_eq("rst_rdata", s_axi_rdata, '0);
    check_eq("rst_rresp", s_axi_rresp, '0);
    check_eq("rst_rlast", s_axi_rlast, '0);
`ifdef PICO_RESP_ROUTER_ERR_EN
    check_eq("rst_err", err_flag, '0);
`endif
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input bit issue, input int slave, input bit mv, input logic [DW-1:0] md,
                      input logic [1:0] mr, input bit ml, input logic [NS-1:0] sr,
                      output bit acc);
    bit            full, taken, exp_rdy;
    logic [NS-1:0] exp_sv;
    @(negedge clk);
    req_issue    = issue;
    req_slave    = slave[1:0];
    m_axi_rvalid = mv;
    m_axi_rdata  = md;
    m_axi_rresp  = mr;
    m_axi_rlast  = ml;
    s_axi_rready = sr;
    #1;
    full    = (q.size() == DEPTH);
    taken   = ov && ((os >= NS) || sr[os]);
    exp_rdy = (q.size() > 0) && (!ov || taken);
    exp_sv  = '0;
    if (ov && os < NS) exp_sv[os] = 1'b1;
    check_eq("m_rready", m_axi_rready, exp_rdy);
    check_eq("s_rvalid", s_axi_rvalid, exp_sv);
    check_eq("outstanding", outstanding, q.size());
    check_eq("order_full", order_full, full);
    if (ov) begin
      check_eq("s_rdata", s_axi_rdata, od);
      check_eq("s_rresp", s_axi_rresp, orr);
      check_eq("s_rlast", s_axi_rlast, ol);
    end
`ifdef PICO_RESP_ROUTER_ERR_EN
    check_eq("err_flag", err_flag, err);
`endif
    acc = mv && exp_rdy;
    if (issue && full) err = 1;
    if (issue && !full && slave >= NS) err = 1;
    if (mv && q.size() == 0) begin
      stall_cycles++;
      if (stall_cycles >= 16) err = 1;
    end else begin
      stall_cycles = 0;
    end
    if (acc) begin
      ov = 1; os = q[0]; od = md; orr = mr; ol = ml;
      if (ml) void'(q.pop_front());
    end else if (taken) begin
      ov = 0;
    end
    if (issue && !full) q.push_back(slave);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 2'b00, 0, 4'hF, acc);
  endtask

  task automatic issue(input int slave);
    bit acc;
    step(1, slave, 0, '0, 2'b00, 0, 4'hF, acc);
  endtask

  // Present one beat until the model says it was accepted, with a bounded retry count.
  task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] r, input bit l,
                           input logic [NS-1:0] sr);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(0, 0, 1, d, r, l, sr, acc);
      tries++;
    end
    check_eq("beat_accept", acc, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_issue = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
    #1;
    model_reset();
    check_reset_state();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int b;
    rst_n = 1'b0;
    req_issue = 0; req_slave = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
    m_axi_rresp = 0; m_axi_rlast = 0; s_axi_rready = '1;
    model_reset();
    #3;
    check_reset_state();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single slave, 4-beat burst.
    issue(2);
    for (int i = 0; i < 4; i++) send_beat(DW'(32'h10 + i), 2'b00, i == 3, 4'hF);
    idle(2);

    // Back-to-back grants, single-beat bursts routed in grant order.
    issue(3); issue(0); issue(1);
    send_beat(DW'(32'hA), 2'b01, 1, 4'hF);
    send_beat(DW'(32'hB), 2'b10, 1, 4'hF);
    send_beat(DW'(32'hC), 2'b11, 1, 4'hF);
    idle(2);

    // Slave backpressure holds the output and the master side.
    issue(1);
    b = 0;
    for (int cyc = 0; cyc < 20 && b < 3; cyc++) begin
      step(0, 0, 1, DW'(32'h100 + b), 2'b00, b == 2,
           (cyc >= 2 && cyc <= 5) ? 4'b1101 : 4'hF, acc);
      if (acc) b++;
    end
    check_eq("bp_burst_done", b, 3);
    idle(2);

    // Fill to full, drop the 17th grant, drain, then route across the wrap.
    for (int i = 0; i < DEPTH + 1; i++) issue(i % NS);
    for (int i = 0; i < DEPTH; i++) send_beat(DW'(32'h200 + i), 2'b00, 1, 4'hF);
    idle(1);
    issue(2);
    send_beat(DW'(32'h300), 2'b00, 1, 4'hF);
    idle(2);

    // Master valid with nothing queued: stalled, never accepted.
    for (int i = 0; i < 20; i++) step(0, 0, 1, DW'(32'hDEAD), 2'b00, 1, 4'hF, acc);
    idle(1);

    // Reset in the middle of a burst, then a fresh transaction.
    issue(0);
    send_beat(DW'(32'h400), 2'b00, 0, 4'hF);
    send_beat(DW'(32'h401), 2'b00, 0, 4'hF);
    async_reset();
    issue(0);
    send_beat(DW'(32'h500), 2'b00, 1, 4'hF);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) == 0, $urandom % NS, $urandom % 2,
           {$urandom, $urandom, $urandom, $urandom}, 2'($urandom), ($urandom % 3) == 0,
           4'($urandom), acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
